// File: rtl/fp_pkg.sv
// Shared floating-point types, default widths, flag indices and operand classification.
package fp_pkg;

    localparam int DEF_EXP_W = 8;
    localparam int DEF_MAN_W = 7;
    localparam int BIAS      = 2 ** (DEF_EXP_W - 1) - 1;
    localparam int W         = 1 + DEF_EXP_W + DEF_MAN_W;

    typedef enum logic [2:0] {
        ZERO,
        NORM,
        INF,
        QNAN,
        SNAN
    } fp_class_e;

    localparam int FLG_NV = 3;
    localparam int FLG_OF = 2;
    localparam int FLG_UF = 1;
    localparam int FLG_NX = 0;

    // Subnormals land in ZERO (denormals-are-zero).
    function automatic fp_class_e fp_classify(
        input logic exp_zero,
        input logic exp_ones,
        input logic frac_zero,
        input logic quiet
    );
        if (exp_zero) return ZERO;
        if (!exp_ones) return NORM;
        if (frac_zero) return INF;
        if (quiet) return QNAN;
        return SNAN;
    endfunction

endpackage

// File: rtl/fp_round_norm.sv
// Normalise, round and range-check a raw significand product (shared with the adder).
module fp_round_norm
    import fp_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W
) (
    input  logic [2*MAN_W+1:0]      prod,
    input  logic signed [EXP_W+1:0] esum,
    input  logic                    sign,
    input  logic                    rnd_mode,
    output logic [EXP_W+MAN_W:0]    result,
    output logic [3:0]              flags
);

    localparam logic signed [EXP_W+1:0] E_MAX =
        (EXP_W + 2)'(2 ** EXP_W - 1);

    logic                    norm;
    logic                    g;
    logic                    s;
    logic                    inc;
    logic                    carry;
    logic [MAN_W-1:0]        frac;
    logic [MAN_W-1:0]        frac_r;
    logic signed [EXP_W+1:0] e_n;
    logic signed [EXP_W+1:0] e_f;

    always_comb begin
        norm = prod[2*MAN_W+1];
        frac = norm ? prod[2*MAN_W:MAN_W+1] : prod[2*MAN_W-1:MAN_W];
        g    = norm ? prod[MAN_W] : prod[MAN_W-1];
        s    = norm ? |prod[MAN_W-1:0] : |prod[MAN_W-2:0];
        inc  = !rnd_mode & g & (s | frac[0]);

        // A carry out leaves frac_r at zero, which is the renormalised fraction.
        {carry, frac_r} = {1'b0, frac} + (MAN_W + 1)'(inc);
        e_n = esum + $signed((EXP_W + 2)'(norm));
        e_f = e_n + $signed((EXP_W + 2)'(carry));

        flags         = '0;
        flags[FLG_NX] = g | s;
        result        = {sign, e_f[EXP_W-1:0], frac_r};

        if (e_f >= E_MAX) begin
            result        = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags[FLG_OF] = 1'b1;
            flags[FLG_NX] = 1'b1;
        end else if (e_f[EXP_W+1] || e_f == '0) begin
            result        = {sign, {(EXP_W + MAN_W){1'b0}}};
            flags[FLG_UF] = 1'b1;
            flags[FLG_NX] = 1'b1;
        end
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier with global-stall flow control.
module fp_mul_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a_op,
    input  logic [EXP_W+MAN_W:0]   b_op,
    input  logic [TAG_W-1:0]       in_tag,
    input  logic                   rnd_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [TAG_W-1:0]       out_tag,
    output logic [3:0]             flags
);

    localparam int WID = 1 + EXP_W + MAN_W;
    localparam int PW  = 2 * MAN_W + 2;
    localparam logic signed [EXP_W+1:0] EBIAS =
        (EXP_W + 2)'(2 ** (EXP_W - 1) - 1);
    localparam logic [WID-1:0] QNAN_W =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};

    logic advance;

    logic             sa;
    logic             sb;
    logic [EXP_W-1:0] ea;
    logic [EXP_W-1:0] eb;
    logic [MAN_W-1:0] fa;
    logic [MAN_W-1:0] fb;
    fp_class_e        ca;
    fp_class_e        cb;

    logic                    sign_d;
    logic signed [EXP_W+1:0] esum_d;
    logic                    is_nan;
    logic                    inf_zero;
    logic                    spec_d;
    logic                    nv_d;
    logic [WID-1:0]          spec_res_d;

    logic                    s1_valid;
    logic                    s1_sign;
    logic signed [EXP_W+1:0] s1_esum;
    logic [MAN_W:0]          s1_siga;
    logic [MAN_W:0]          s1_sigb;
    logic                    s1_spec;
    logic                    s1_nv;
    logic [WID-1:0]          s1_spec_res;
    logic                    s1_rnd;
    logic [TAG_W-1:0]        s1_tag;

    logic                    s2_valid;
    logic                    s2_sign;
    logic signed [EXP_W+1:0] s2_esum;
    logic [PW-1:0]           s2_prod;
    logic                    s2_spec;
    logic                    s2_nv;
    logic [WID-1:0]          s2_spec_res;
    logic                    s2_rnd;
    logic [TAG_W-1:0]        s2_tag;

    logic [WID-1:0] rn_result;
    logic [3:0]     rn_flags;

    assign advance  = !out_valid | out_ready;
    assign in_ready = advance;

    assign {sa, ea, fa} = a_op;
    assign {sb, eb, fb} = b_op;

    assign ca = fp_classify(ea == '0, &ea, fa == '0, fa[MAN_W-1]);
    assign cb = fp_classify(eb == '0, &eb, fb == '0, fb[MAN_W-1]);

    assign sign_d = sa ^ sb;
    assign esum_d = $signed({2'b00, ea}) + $signed({2'b00, eb}) - EBIAS;

    // NaN outranks inf*0, which outranks inf, which outranks zero.
    always_comb begin
        spec_d     = 1'b0;
        nv_d       = 1'b0;
        spec_res_d = '0;
        is_nan     = (ca == QNAN) | (ca == SNAN) |
                     (cb == QNAN) | (cb == SNAN);
        inf_zero   = ((ca == INF) & (cb == ZERO)) |
                     ((ca == ZERO) & (cb == INF));
        if (is_nan | inf_zero) begin
            spec_d     = 1'b1;
            spec_res_d = QNAN_W;
            nv_d       = inf_zero | (ca == SNAN) | (cb == SNAN);
        end else if ((ca == INF) | (cb == INF)) begin
            spec_d     = 1'b1;
            spec_res_d = {sign_d, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if ((ca == ZERO) | (cb == ZERO)) begin
            spec_d     = 1'b1;
            spec_res_d = {sign_d, {(EXP_W + MAN_W){1'b0}}};
        end
    end

    fp_round_norm #(
        .EXP_W(EXP_W),
        .MAN_W(MAN_W)
    ) u_round (
        .prod    (s2_prod),
        .esum    (s2_esum),
        .sign    (s2_sign),
        .rnd_mode(s2_rnd),
        .result  (rn_result),
        .flags   (rn_flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_sign     <= 1'b0;
            s1_esum     <= '0;
            s1_siga     <= '0;
            s1_sigb     <= '0;
            s1_spec     <= 1'b0;
            s1_nv       <= 1'b0;
            s1_spec_res <= '0;
            s1_rnd      <= 1'b0;
            s1_tag      <= '0;
            s2_valid    <= 1'b0;
            s2_sign     <= 1'b0;
            s2_esum     <= '0;
            s2_prod     <= '0;
            s2_spec     <= 1'b0;
            s2_nv       <= 1'b0;
            s2_spec_res <= '0;
            s2_rnd      <= 1'b0;
            s2_tag      <= '0;
            out_valid   <= 1'b0;
            result      <= '0;
            out_tag     <= '0;
            flags       <= '0;
        end else if (advance) begin
            s1_valid    <= in_valid;
            s1_sign     <= sign_d;
            s1_esum     <= esum_d;
            s1_siga     <= {1'b1, fa};
            s1_sigb     <= {1'b1, fb};
            s1_spec     <= spec_d;
            s1_nv       <= nv_d;
            s1_spec_res <= spec_res_d;
            s1_rnd      <= rnd_mode;
            s1_tag      <= in_tag;

            s2_valid    <= s1_valid;
            s2_sign     <= s1_sign;
            s2_esum     <= s1_esum;
            s2_prod     <= s1_siga * s1_sigb;
            s2_spec     <= s1_spec;
            s2_nv       <= s1_nv;
            s2_spec_res <= s1_spec_res;
            s2_rnd      <= s1_rnd;
            s2_tag      <= s1_tag;

            out_valid   <= s2_valid;
            result      <= s2_spec ? s2_spec_res : rn_result;
            flags       <= s2_spec ? {s2_nv, 3'b000} : rn_flags;
            out_tag     <= s2_tag;
        end
    end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboard bench for fp_mul_pipe: directed bf16 vectors, backpressure, reset and random ops.
module tb_fp_mul_pipe;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  flg;
        logic [3:0]  tag;
        int          cyc;
        bit          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a_op;
    logic [15:0] b_op;
    logic [3:0]  in_tag;
    logic        rnd_mode;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] result;
    logic [3:0]  out_tag;
    logic [3:0]  flags;

    exp_t       sb[$];
    exp_t       mon_e;
    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         mode = 0;
    int         bp_start = 0;
    bit         saw_stall = 0;
    logic [3:0] tag_ctr = 4'd0;

    fp_mul_pipe dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_op     (a_op),
        .b_op     (b_op),
        .in_tag   (in_tag),
        .rnd_mode (rnd_mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .out_tag  (out_tag),
        .flags    (flags)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Sink: 0 always ready, 1 stall window, 2 random, 3 never ready.
    always @(posedge clk) begin
        #1;
        case (mode)
            0: out_ready = 1'b1;
            1: out_ready = !((cyc - bp_start) >= 4 && (cyc - bp_start) <= 8);
            2: out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (mode == 1 && in_valid && !in_ready) saw_stall = 1;
            if (out_valid && out_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: got result=%h tag=%h, required none",
                             result, out_tag);
                end else begin
                    mon_e = sb.pop_front();
                    if (result !== mon_e.res || flags !== mon_e.flg ||
                        out_tag !== mon_e.tag) begin
                        n_fail++;
                        $display("FAIL vector tag%0d: got res=%h flg=%b tag=%h, required res=%h flg=%b tag=%h",
                                 mon_e.tag, result, flags, out_tag,
                                 mon_e.res, mon_e.flg, mon_e.tag);
                    end
                    if (mon_e.lat) begin
                        n_checks++;
                        if (cyc - mon_e.cyc != 3) begin
                            n_fail++;
                            $display("FAIL latency tag%0d: got %0d cycles, required 3",
                                     mon_e.tag, cyc - mon_e.cyc);
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, got, req);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the transfer edge.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic rnd,
                        input logic [15:0] er, input logic [3:0] ef, input bit lat);
        exp_t e;
        int   tries;
        in_valid = 1'b1;
        a_op     = a;
        b_op     = b;
        rnd_mode = rnd;
        in_tag   = tag_ctr;
        tries    = 0;
        @(negedge clk);
        while (!in_ready && tries < 200) begin
            tries++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout tag%0d: got in_ready=0, required 1", tag_ctr);
        end else begin
            e.res = er;
            e.flg = ef;
            e.tag = tag_ctr;
            e.cyc = cyc;
            e.lat = lat;
            sb.push_back(e);
        end
        tag_ctr++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain_pending", 32'(sb.size()), 0);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    function automatic void ref_mul(input logic [15:0] a, input logic [15:0] b,
                                    input logic rnd, output logic [15:0] r,
                                    output logic [3:0] f);
        int   ea, eb, fa, fb, p, e, sh, m, rem, half;
        logic s, za, zb, ia, ib, na, nb, sna, snb, iz;
        s   = a[15] ^ b[15];
        ea  = int'(a[14:7]);
        eb  = int'(b[14:7]);
        fa  = int'(a[6:0]);
        fb  = int'(b[6:0]);
        za  = (ea == 0);
        zb  = (eb == 0);
        ia  = (ea == 255 && fa == 0);
        ib  = (eb == 255 && fb == 0);
        na  = (ea == 255 && fa != 0);
        nb  = (eb == 255 && fb != 0);
        sna = na && !a[6];
        snb = nb && !b[6];
        iz  = (ia && zb) || (za && ib);
        f   = 4'b0000;
        r   = 16'h0000;
        if (na || nb || iz) begin
            r    = 16'h7FC0;
            f[3] = iz || sna || snb;
        end else if (ia || ib) begin
            r = {s, 15'h7F80};
        end else if (za || zb) begin
            r = {s, 15'h0000};
        end else begin
            p  = (128 + fa) * (128 + fb);
            e  = ea + eb - 127;
            sh = 7;
            if (p >= 32768) begin
                sh = 8;
                e  = e + 1;
            end
            m    = p >> sh;
            rem  = p & ((1 << sh) - 1);
            half = 1 << (sh - 1);
            f[0] = (rem != 0);
            if (!rnd && (rem > half || (rem == half && (m % 2) == 1))) m = m + 1;
            if (m == 256) begin
                m = 128;
                e = e + 1;
            end
            if (e >= 255) begin
                r = {s, 15'h7F80};
                f = 4'b0101;
            end else if (e <= 0) begin
                r = {s, 15'h0000};
                f = 4'b0011;
            end else begin
                r = {s, 8'(e), 7'(m)};
            end
        end
    endfunction

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra, rb, rr;
        logic [3:0]  rf;
        logic        rm;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        a_op     = '0;
        b_op     = '0;
        in_tag   = '0;
        rnd_mode = 1'b0;
        mode     = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_result", 32'(result), 0);
        chk("reset_out_tag", 32'(out_tag), 0);
        chk("reset_flags", 32'(flags), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_in_ready", 32'(in_ready), 1);

        send(16'h3F80, 16'h4000, 1'b0, 16'h4000, 4'b0000, 1);
        send(16'h3FC0, 16'h3FC0, 1'b0, 16'h4010, 4'b0000, 1);
        send(16'h3F81, 16'h3FC0, 1'b0, 16'h3FC2, 4'b0001, 1);
        send(16'h3F81, 16'h3FC0, 1'b1, 16'h3FC1, 4'b0001, 1);
        send(16'h7F80, 16'h0000, 1'b0, 16'h7FC0, 4'b1000, 1);
        send(16'hFF80, 16'h4000, 1'b0, 16'hFF80, 4'b0000, 1);
        send(16'h7F00, 16'h7F00, 1'b0, 16'h7F80, 4'b0101, 1);
        send(16'h0080, 16'h3F00, 1'b0, 16'h0000, 4'b0011, 1);
        send(16'h0001, 16'h4000, 1'b0, 16'h0000, 4'b0000, 1);
        send(16'h7F81, 16'h3F80, 1'b0, 16'h7FC0, 4'b1000, 1);
        send(16'h7FC0, 16'h0000, 1'b0, 16'h7FC0, 4'b0000, 1);
        send(16'hBF80, 16'h4000, 1'b0, 16'hC000, 4'b0000, 1);
        drain();

        saw_stall = 0;
        bp_start  = cyc;
        mode      = 1;
        for (int i = 0; i < 10; i++)
            send(16'h4000 + 16'(i * 3), 16'h3F80, 1'b0,
                 16'h4000 + 16'(i * 3), 4'b0000, 0);
        drain();
        chk("stall_seen", 32'(saw_stall), 1);

        mode = 3;
        send(16'h4100, 16'h3F80, 1'b0, 16'h4100, 4'b0000, 0);
        send(16'h4101, 16'h3F80, 1'b0, 16'h4101, 4'b0000, 0);
        send(16'h4102, 16'h3F80, 1'b0, 16'h4102, 4'b0000, 0);
        chk("prefill_out_valid", 32'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_out_valid", 32'(out_valid), 0);
        chk("async_reset_in_ready", 32'(in_ready), 1);
        sb.delete();
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        mode  = 0;
        @(posedge clk);
        #1;
        send(16'h4040, 16'h4000, 1'b0, 16'h40C0, 4'b0000, 1);
        drain();

        mode = 2;
        for (int i = 0; i < 10000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 3) != 0) ra[14:7] = 8'($urandom_range(100, 154));
            if ($urandom_range(0, 3) != 0) rb[14:7] = 8'($urandom_range(100, 154));
            rm = 1'($urandom_range(0, 1));
            ref_mul(ra, rb, rm, rr, rf);
            send(ra, rb, rm, rr, rf, 0);
        end
        mode = 0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
